stall_control_unit: RTL and testbench
=====================================

# stall_control_unit

Parametrised successor to the fixed-format stall controller. It decodes the opcode field of each fetched instruction and holds the pipeline for a configurable number of cycles after jumps and loads. Halt freezes the pipeline until reset. An external stall request (memory wait) passes through, and a saturating stall-cycle counter is provided for performance monitoring. The block sits between program memory and the pipeline registers; `stall` holds the pipeline and `stall_pm` holds the PC/program-memory fetch one cycle later.

## Interface
- `INSTR_W`, 20, instruction width
- `OPC_W`, 5, opcode width; opcode = `ins_pm[INSTR_W-1 -: OPC_W]`
- `OPC_JMP`, 5'b10100, jump/branch opcode
- `OPC_LD`, 5'b10001, load opcode
- `OPC_HLT`, 5'b11110, halt opcode
- `JMP_STALL`, 2, stall cycles after jump (0..15; 0 = no stall)
- `LD_STALL`, 1, stall cycles after load (0..15; 0 = no stall)
- `PERF_W`, 16, stall-cycle counter width

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `ins_pm` in INSTR_W: instruction from program memory
- `ext_stall` in 1: external stall request (combinational pass-through)
- `stall` out 1: pipeline hold
- `stall_pm` out 1: PC/program-memory hold; `stall` delayed one cycle
- `halted` out 1: high in HALT state
- `stall_cycles` out PERF_W: saturating count of cycles with `stall`=1

## Operation
- FSM states: IDLE, JSTALL, LSTALL, HALT. Reset → IDLE; count register = 0; `stall_pm`=0; `stall_cycles`=0.
- Decode occurs only in IDLE when `ext_stall`=0. While `ext_stall`=1, `ins_pm` is ignored and the state is held.
- IDLE + OPC_HLT → HALT.
- IDLE + OPC_JMP with JMP_STALL>0 → JSTALL; count loads JMP_STALL-1.
- IDLE + OPC_LD with LD_STALL>0 → LSTALL; count loads LD_STALL-1.
- Any other opcode, or a class whose stall parameter is 0 → stay in IDLE.
- JSTALL/LSTALL: if count==0, go to IDLE; else decrement. `ins_pm` is ignored. `ext_stall` does not pause the count.
- HALT is left only by reset; `ins_pm` and `ext_stall` are ignored.
- `stall` = !reset & ((state!=IDLE) | ext_stall). This is the only combinational path (`ext_stall` → `stall`).
- `stall_pm` is a register: `stall_pm` <= `stall`.
- `halted` = (state==HALT).
- `stall_cycles` increments on each rising edge where `stall`=1 and saturates at 2^PERF_W-1. No wrap.
- Reset asserted mid-stall or in HALT: all outputs go to 0 immediately (asynchronous); the count is discarded.

## Timing
- Jump sampled at edge k (IDLE, `ext_stall`=0):
  - `stall`=1 for cycles k+1 … k+JMP_STALL.
  - `stall_pm`=1 for k+2 … k+JMP_STALL+1.
- Load: same pattern with LD_STALL.
- A decode-triggering instruction present on the edge that returns to IDLE is ignored; decode resumes the following edge.
- Back-to-back jumps with JMP_STALL=2 therefore yield `stall` pattern 1,1,0,1,1.
- Halt at edge k: `stall` and `halted` = 1 from k+1, `stall_pm` from k+2, indefinitely.
- `ext_stall` rising mid-cycle: `stall` rises in the same cycle; `stall_pm` follows at the next edge.

## Structure
- Package `stall_ctrl_pkg` holds:
  - the state enum (IDLE/JSTALL/LSTALL/HALT, 2-bit);
  - default opcode constants OPC_JMP/OPC_LD/OPC_HLT;
  - the count width constant (4).
- One sub-module, `stall_counter`: loadable 4-bit down-counter with `load`, `load_val`, `dec`, and a `zero` flag. The top level holds the FSM, the `stall_pm` register, and the perf counter.

## Test plan
- Reset then release, `ins_pm`=20'h00000 for 5 cycles → `stall`=0, `stall_pm`=0, `halted`=0, `stall_cycles`=0.
- `ins_pm`=20'hA0000 for one edge, JMP_STALL=2 → `stall` high for exactly 2 cycles, `stall_pm` high for 2 cycles one cycle later, `stall_cycles`=2.
- `ins_pm`=20'h88000 with LD_STALL=1 → `stall` high for 1 cycle; with LD_STALL=0 → no stall.
- `ins_pm`=20'hF0000 → `halted`=1 and `stall`=1 for 100 cycles regardless of `ins_pm`/`ext_stall`. Then assert `reset` mid-cycle → all outputs 0 immediately, and the state is IDLE after release.
- `ext_stall`=1 for 3 cycles while `ins_pm`=20'hA0000 → `stall` follows `ext_stall` and no JSTALL entry occurs. On release, the jump decodes and 2 stall cycles follow. `stall_cycles`=5.
- PERF_W=4, hold HALT for 20 cycles → `stall_cycles` saturates at 15.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// rtl/stall_ctrl_pkg.sv - shared types and constants for the stall controller
// Contents: FSM state enum, default opcode encodings, stall-count register width.
package stall_ctrl_pkg;

  // Width of the stall down-counter; stall parameters range 0..15.
  localparam int CNT_W = 4;

  // Default opcode encodings (top 5 bits of the instruction word).
  localparam logic [4:0] OPC_JMP_DEF = 5'b10100;
  localparam logic [4:0] OPC_LD_DEF  = 5'b10001;
  localparam logic [4:0] OPC_HLT_DEF = 5'b11110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_JSTALL = 2'd1,
    ST_LSTALL = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

endpackage

// File: rtl/stall_control_unit_counter.sv
// rtl/stall_control_unit_counter.sv - loadable down-counter timing jump/load stalls
// Ports: clk, rst (async, active-high), load_i/load_val_i (load), dec_i (decrement),
//        zero_o (count is zero).
module stall_counter
  import stall_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load wins over decrement; decrement stops at zero so a stray dec never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/stall_control_unit.sv
// rtl/stall_control_unit.sv - opcode-driven pipeline stall controller with perf counter
// Ports: clk, reset (async, active-high), ins_pm (fetched instruction),
//        ext_stall (external hold request), stall (pipeline hold),
//        stall_pm (PC/fetch hold, stall delayed one cycle), halted (in HALT),
//        stall_cycles (saturating count of stalled cycles).
module stall_control_unit
  import stall_ctrl_pkg::*;
#(
  parameter int                 INSTR_W   = 20,
  parameter int                 OPC_W     = 5,
  parameter logic [OPC_W-1:0]   OPC_JMP   = OPC_JMP_DEF,
  parameter logic [OPC_W-1:0]   OPC_LD    = OPC_LD_DEF,
  parameter logic [OPC_W-1:0]   OPC_HLT   = OPC_HLT_DEF,
  parameter int                 JMP_STALL = 2,
  parameter int                 LD_STALL  = 1,
  parameter int                 PERF_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] ins_pm,
  input  logic               ext_stall,
  output logic               stall,
  output logic               stall_pm,
  output logic               halted,
  output logic [PERF_W-1:0]  stall_cycles
);

  // The counter holds "cycles remaining after this one", so it loads N-1.
  localparam logic [CNT_W-1:0] JMP_LOAD = (JMP_STALL > 0) ? CNT_W'(JMP_STALL - 1) : '0;
  localparam logic [CNT_W-1:0] LD_LOAD  = (LD_STALL > 0)  ? CNT_W'(LD_STALL - 1)  : '0;
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  state_e            state_q;
  state_e            state_d;
  logic              stall_pm_q;
  logic              stall_pm_d;
  logic [PERF_W-1:0] perf_q;
  logic [PERF_W-1:0] perf_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_dec;
  logic              cnt_zero;

  logic [OPC_W-1:0]  opc;
  logic              unused_ins_low;

  assign opc            = ins_pm[INSTR_W-1 -: OPC_W];
  assign unused_ins_low = ^ins_pm[INSTR_W-OPC_W-1:0];

  stall_counter u_counter (
    .clk        (clk),
    .rst        (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Decode only from IDLE with no external hold; stall states run to completion
  // regardless of ext_stall, and an instruction on the returning edge is dropped.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ext_stall) begin
          if (opc == OPC_HLT) begin
            state_d = ST_HALT;
          end else if ((opc == OPC_JMP) && (JMP_STALL > 0)) begin
            state_d      = ST_JSTALL;
            cnt_load     = 1'b1;
            cnt_load_val = JMP_LOAD;
          end else if ((opc == OPC_LD) && (LD_STALL > 0)) begin
            state_d      = ST_LSTALL;
            cnt_load     = 1'b1;
            cnt_load_val = LD_LOAD;
          end
        end
      end
      ST_JSTALL, ST_LSTALL: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset gates stall directly so it drops the instant reset rises.
  assign stall  = !reset && ((state_q != ST_IDLE) || ext_stall);
  assign halted = (state_q == ST_HALT);

  always_comb begin
    stall_pm_d = stall;
    perf_d     = perf_q;
    if (stall && (perf_q != PERF_MAX)) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      stall_pm_q <= 1'b0;
      perf_q     <= '0;
    end else begin
      state_q    <= state_d;
      stall_pm_q <= stall_pm_d;
      perf_q     <= perf_d;
    end
  end

  assign stall_pm     = stall_pm_q;
  assign stall_cycles = perf_q;

endmodule

// File: tb/tb_stall_control_unit.sv
// tb/tb_stall_control_unit.sv - bench for stall_control_unit
module tb_stall_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] ins_pm;
  logic        ext_stall;
  logic        stall;
  logic        stall_pm;
  logic        halted;
  logic [15:0] stall_cycles;

  logic [19:0] ins2;
  logic        ext2;
  logic        stall2;
  logic        pm2;
  logic        halted2;
  logic [3:0]  cyc2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stall_control_unit dut (
    .clk          (clk),
    .reset        (reset),
    .ins_pm       (ins_pm),
    .ext_stall    (ext_stall),
    .stall        (stall),
    .stall_pm     (stall_pm),
    .halted       (halted),
    .stall_cycles (stall_cycles)
  );

  stall_control_unit #(
    .JMP_STALL (3),
    .LD_STALL  (0),
    .PERF_W    (4)
  ) dut2 (
    .clk          (clk),
    .reset        (reset),
    .ins_pm       (ins2),
    .ext_stall    (ext2),
    .stall        (stall2),
    .stall_pm     (pm2),
    .halted       (halted2),
    .stall_cycles (cyc2)
  );

  typedef struct {
    logic [19:0] ins;
    logic        ext;
    logic        st;
    logic        pm;
    logic [15:0] cyc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [19:0] ins, input logic ext, input logic st,
                              input logic pm, input logic [15:0] cyc);
    vec_t v;
    v.ins = ins; v.ext = ext; v.st = st; v.pm = pm; v.cyc = cyc;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {ins, ext, stall, stall_pm, stall_cycles} per cycle, sampled mid-cycle
    add(20'h00000, 0, 0, 0, 0);
    add(20'h00000, 0, 0, 0, 0);
    add(20'h00000, 0, 0, 0, 0);
    add(20'h00000, 0, 0, 0, 0);
    add(20'h3ABCD, 0, 0, 0, 0);
    add(20'hA0000, 0, 0, 0, 0);   // jump
    add(20'h00000, 0, 1, 0, 0);
    add(20'h00000, 0, 1, 1, 1);
    add(20'h00000, 0, 0, 1, 2);
    add(20'h00000, 0, 0, 0, 2);
    add(20'h88000, 0, 0, 0, 2);   // load
    add(20'h00000, 0, 1, 0, 2);
    add(20'h00000, 0, 0, 1, 3);
    add(20'h7FFFF, 0, 0, 0, 3);   // non-stalling opcode
    add(20'hA0000, 0, 0, 0, 3);   // back-to-back jumps
    add(20'hA0000, 0, 1, 0, 3);
    add(20'hA0000, 0, 1, 1, 4);
    add(20'hA0000, 0, 0, 1, 5);
    add(20'hA0000, 0, 1, 0, 5);
    add(20'h00000, 0, 1, 1, 6);
    add(20'h00000, 0, 0, 1, 7);
    add(20'h00000, 0, 0, 0, 7);
    add(20'hA0000, 1, 1, 0, 7);   // ext_stall masks decode
    add(20'hA0000, 1, 1, 1, 8);
    add(20'hA0000, 1, 1, 1, 9);
    add(20'hA0000, 0, 0, 1, 10);
    add(20'h00000, 0, 1, 0, 10);
    add(20'h00000, 0, 1, 1, 11);
    add(20'h00000, 0, 0, 1, 12);
    add(20'h00000, 0, 0, 0, 12);
    add(20'hA0000, 0, 0, 0, 12);  // ext_stall during jump stall does not pause it
    add(20'h00000, 1, 1, 0, 12);
    add(20'h00000, 1, 1, 1, 13);
    add(20'h00000, 0, 0, 1, 14);
    add(20'h00000, 0, 0, 0, 14);

    reset = 1'b1; ins_pm = '0; ext_stall = 1'b0; ins2 = '0; ext2 = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_pm", stall_pm, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cycles", stall_cycles, 0);
    ext_stall = 1'b1;
    #1;
    chk("rst_masks_ext", stall, 0);
    ext_stall = 1'b0;
    next_cycle();
    reset = 1'b0;

    foreach (tbl[i]) begin
      ins_pm = tbl[i].ins;
      ext_stall = tbl[i].ext;
      #3;
      chk($sformatf("vec%0d_stall", i), stall, tbl[i].st);
      chk($sformatf("vec%0d_pm", i), stall_pm, tbl[i].pm);
      chk($sformatf("vec%0d_halted", i), halted, 0);
      chk($sformatf("vec%0d_cycles", i), stall_cycles, tbl[i].cyc);
      next_cycle();
    end

    // Halt: frozen for 100 cycles whatever the inputs do.
    ins_pm = 20'hF0000; ext_stall = 1'b0;
    #3;
    chk("halt_entry_stall", stall, 0);
    next_cycle();
    for (int i = 0; i < 100; i++) begin
      ins_pm = 20'($urandom);
      ext_stall = 1'($urandom_range(0, 1));
      #3;
      chk($sformatf("halt%0d_halted", i), halted, 1);
      chk($sformatf("halt%0d_stall", i), stall, 1);
      chk($sformatf("halt%0d_pm", i), stall_pm, (i == 0) ? 0 : 1);
      next_cycle();
    end
    ins_pm = '0; ext_stall = 1'b0;
    #3;
    chk("halt_cycles", stall_cycles, 114);
    reset = 1'b1;
    #1;
    chk("halt_rst_stall", stall, 0);
    chk("halt_rst_pm", stall_pm, 0);
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_cycles", stall_cycles, 0);
    next_cycle();
    reset = 1'b0;
    #3;
    chk("post_rst_halted", halted, 0);
    chk("post_rst_stall", stall, 0);
    next_cycle();
    #3;
    chk("post_rst2_stall", stall, 0);
    chk("post_rst2_pm", stall_pm, 0);

    // Reset in the middle of a jump stall discards the remaining count.
    next_cycle();
    ins_pm = 20'hA0000;
    next_cycle();
    ins_pm = '0;
    #3;
    chk("midstall_stall", stall, 1);
    reset = 1'b1;
    #1;
    chk("midstall_rst_stall", stall, 0);
    #1;
    reset = 1'b0;
    #1;
    chk("midstall_rel_stall", stall, 0);
    next_cycle();
    #3;
    chk("midstall_after_stall", stall, 0);
    chk("midstall_after_pm", stall_pm, 0);
    next_cycle();

    // Second instance: LD_STALL=0, JMP_STALL=3, 4-bit perf counter.
    ins2 = 20'h88000;
    #3;
    chk("d2_ld_stall0", stall2, 0);
    next_cycle();
    ins2 = '0;
    for (int i = 0; i < 2; i++) begin
      #3;
      chk($sformatf("d2_ld_nostall%0d", i), stall2, 0);
      next_cycle();
    end
    ins2 = 20'hA0000;
    next_cycle();
    ins2 = '0;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk($sformatf("d2_jmp%0d_stall", i), stall2, (i < 3) ? 1 : 0);
      next_cycle();
    end
    #3;
    chk("d2_jmp_cycles", cyc2, 3);
    ins2 = 20'hF0000;
    next_cycle();
    ins2 = '0;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (i == 11) chk("d2_cycles_presat", cyc2, 14);
      next_cycle();
    end
    #3;
    chk("d2_cycles_sat", cyc2, 15);
    chk("d2_halted", halted2, 1);
    chk("d1_idle_meanwhile", stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
